complex_multiplier_seq: RTL

//  Multi-cycle signed complex multiplier.

---
 rtl/complex_multiplier_seq_pkg.sv | 22 ++
 rtl/complex_multiplier_seq_signed_mult_nxn.sv | 13 +
 rtl/complex_multiplier_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/complex_multiplier_seq_pkg.sv
// Shared widths and FSM state encoding for the sequential complex multiplier.
package complex_multiplier_seq_pkg;

   localparam int N      = 8;
   localparam int PROD_W = 2 * N;
   localparam int RES_W  = 2 * N + 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P0   = 3'd1,
      P1   = 3'd2,
      P2   = 3'd3,
      P3   = 3'd4,
      OUT  = 3'd5
   } state_t;

   // Sign-extend a full-width product into the accumulator width.
   function automatic logic signed [RES_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
      return RES_W'($signed(p));
   endfunction

endpackage

// File: rtl/complex_multiplier_seq_signed_mult_nxn.sv
// Combinational N x N two's-complement multiplier producing an exact 2N-bit product.
module complex_multiplier_seq_signed_mult_nxn
   import complex_multiplier_seq_pkg::*;
(
   input  logic [N-1:0]      a,
   input  logic [N-1:0]      b,
   output logic [PROD_W-1:0] p
);

   // The 2N-bit truncation is exact: the largest magnitude is (-2^(N-1))^2 = 2^(2N-2).
   assign p = PROD_W'($signed(a)) * PROD_W'($signed(b));

endmodule

// File: rtl/complex_multiplier_seq.sv
// Four-step signed complex multiplier sharing one N x N multiplier, with
// valid/ready handshakes on operand and result sides.
module complex_multiplier_seq
   import complex_multiplier_seq_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             conj_b,
   input  logic [N-1:0]     areal,
   input  logic [N-1:0]     aimaginary,
   input  logic [N-1:0]     breal,
   input  logic [N-1:0]     bimaginary,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] resultreal,
   output logic [RES_W-1:0] resultimaginary,
   output logic [2:0]       dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; out_valid and the results stay stable until out_ready is seen.

   state_t                  state;
   logic [N-1:0]            ar_q, ai_q, br_q, bi_q;
   logic                    conj_q;
   logic signed [RES_W-1:0] re_acc, im_acc;
   logic [N-1:0]            mult_a, mult_b;
   logic [PROD_W-1:0]       prod;
   logic signed [RES_W-1:0] prod_ext;

   assign in_ready  = reset_n && (state == IDLE);
   assign dbg_state = state;
   assign prod_ext  = ext_prod(prod);

   // Operand selection for the shared multiplier, one partial product per step.
   always_comb begin
      mult_a = '0;
      mult_b = '0;
      case (state)
         P0:      begin mult_a = ar_q; mult_b = br_q; end
         P1:      begin mult_a = ai_q; mult_b = bi_q; end
         P2:      begin mult_a = ar_q; mult_b = bi_q; end
         P3:      begin mult_a = ai_q; mult_b = br_q; end
         default: begin mult_a = '0;   mult_b = '0;   end
      endcase
   end

   complex_multiplier_seq_signed_mult_nxn u_mult (
      .a (mult_a),
      .b (mult_b),
      .p (prod)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         out_valid       <= 1'b0;
         resultreal      <= '0;
         resultimaginary <= '0;
         ar_q            <= '0;
         ai_q            <= '0;
         br_q            <= '0;
         bi_q            <= '0;
         conj_q          <= 1'b0;
         re_acc          <= '0;
         im_acc          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ar_q   <= areal;
                  ai_q   <= aimaginary;
                  br_q   <= breal;
                  bi_q   <= bimaginary;
                  conj_q <= conj_b;
                  state  <= P0;
               end
            end
            P0: begin
               re_acc <= prod_ext;
               state  <= P1;
            end
            P1: begin
               // Conjugating B flips the sign of bi, so ai*bi is added instead.
               re_acc <= conj_q ? (re_acc + prod_ext) : (re_acc - prod_ext);
               state  <= P2;
            end
            P2: begin
               im_acc <= conj_q ? -prod_ext : prod_ext;
               state  <= P3;
            end
            P3: begin
               resultreal      <= re_acc;
               resultimaginary <= im_acc + prod_ext;
               out_valid       <= 1'b1;
               state           <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
